// File: rtl/wirelog_pkg.sv
// Shared types and helpers for the wire-logic gate/trigger datapath.
package wirelog_pkg;

  localparam int N_GATES_DEF = 16;
  localparam int ID_W_DEF    = $clog2(N_GATES_DEF);

  typedef logic [ID_W_DEF-1:0] gate_id_t;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic int unsigned lowest_set(input logic [63:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_trig_fifo.sv
// Single-clock ordering FIFO for gate IDs; pointers carry an extra wrap bit so
// full and empty are distinguishable at any depth.
module gate_trig_fifo
  import wirelog_pkg::*;
#(
  parameter int DEPTH = N_GATES_DEF,
  parameter int W     = ID_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en;

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
    return p + (AW+1)'(1);
  endfunction

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    dout     = mem_q[rd_ptr_q[AW-1:0]];
    // A pop frees the head slot this cycle, so push is still legal when full.
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = (pop && !empty) ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/gate_trigger_queue.sv
// Serialises one-cycle gate fire pulses into an ordered stream of gate IDs for
// the wire-propagation engine, with drain (idle) and re-fire (dup_err) status.
module gate_trigger_queue
  import wirelog_pkg::*;
#(
  parameter int N_GATES    = N_GATES_DEF,
  parameter int ID_W       = $clog2(N_GATES),
  parameter int FIFO_DEPTH = N_GATES
) (
  input  logic               clk,
  input  logic               logic_reset,
  input  logic [N_GATES-1:0] gate_pulse,
  output logic               trig_valid,
  input  logic               trig_ready,
  output logic [ID_W-1:0]    trig_id,
  output logic               idle,
  output logic               dup_err
);

  logic [N_GATES-1:0] pending_q, pending_d;
  logic [N_GATES-1:0] in_queue_q, in_queue_d;
  logic               dup_err_q, dup_err_d;

  logic [N_GATES-1:0] in_flight, pop_mask, stage_mask, accept;
  logic [ID_W-1:0]    stage_id, fifo_dout;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;

  always_comb begin
    trig_valid = !fifo_empty;
    trig_id    = fifo_empty ? '0 : fifo_dout;
    fifo_pop   = trig_valid && trig_ready;
    pop_mask   = fifo_pop ? (N_GATES'(1) << trig_id) : '0;

    // A gate popped this cycle is no longer in flight, so it may re-fire now.
    in_flight  = (pending_q | in_queue_q) & ~pop_mask;
    accept     = gate_pulse & ~in_flight;

    fifo_push  = |pending_q;
    stage_id   = ID_W'(lowest_set(64'(pending_q)));
    stage_mask = fifo_push ? (N_GATES'(1) << stage_id) : '0;

    pending_d  = (pending_q & ~stage_mask) | accept;
    in_queue_d = (in_queue_q & ~pop_mask) | stage_mask;
    dup_err_d  = dup_err_q || (|(gate_pulse & in_flight));

    idle       = (pending_q == '0) && fifo_empty && (gate_pulse == '0);
    dup_err    = dup_err_q;
  end

  always_ff @(posedge clk) begin
    if (logic_reset) begin
      pending_q  <= '0;
      in_queue_q <= '0;
      dup_err_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      in_queue_q <= in_queue_d;
      dup_err_q  <= dup_err_d;
    end
  end

  gate_trig_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (logic_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (stage_id),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_gate_trigger_queue.sv
// Scoreboard bench: directed stimulus pushes expected IDs, a negedge monitor
// checks every handshake against them.
module tb_gate_trigger_queue;
  import wirelog_pkg::*;

  logic        clk = 1'b0;
  logic        logic_reset;
  logic [15:0] gate_pulse;
  logic        trig_valid;
  logic        trig_ready;
  logic [3:0]  trig_id;
  logic        idle;
  logic        dup_err;

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  gate_id_t exp_q[$];

  gate_trigger_queue #(.N_GATES(16), .ID_W(4), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .logic_reset (logic_reset),
    .gate_pulse  (gate_pulse),
    .trig_valid  (trig_valid),
    .trig_ready  (trig_ready),
    .trig_id     (trig_id),
    .idle        (idle),
    .dup_err     (dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every accepted ID must match the scoreboard head.
  always @(negedge clk) begin
    if (trig_valid && trig_ready) begin
      issued++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=%0d required=none", trig_id);
      end else begin
        chk("issue_id", int'(trig_id), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    smp();
    while (!(idle && exp_q.size() == 0) && n < limit) begin
      cyc();
      smp();
      n++;
    end
    chk({name, "_drained"}, int'(idle && exp_q.size() == 0), 1);
  endtask

  initial begin
    logic_reset = 1'b1;
    gate_pulse  = '0;
    trig_ready  = 1'b0;

    // Reset
    cyc(); cyc();
    logic_reset = 1'b0;
    smp();
    chk("rst_valid", int'(trig_valid), 0);
    chk("rst_id", int'(trig_id), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_dup", int'(dup_err), 0);

    // Single pulse: valid only in cycle 2
    cyc();
    trig_ready = 1'b1;
    gate_pulse = 16'h0020;
    exp_q.push_back(gate_id_t'(5));
    smp();
    chk("sp_c0_idle", int'(idle), 0);
    chk("sp_c0_valid", int'(trig_valid), 0);
    cyc();
    gate_pulse = '0;
    smp();
    chk("sp_c1_valid", int'(trig_valid), 0);
    chk("sp_c1_idle", int'(idle), 0);
    cyc(); smp();
    chk("sp_c2_valid", int'(trig_valid), 1);
    chk("sp_c2_id", int'(trig_id), 5);
    cyc(); smp();
    chk("sp_c3_valid", int'(trig_valid), 0);
    chk("sp_c3_idle", int'(idle), 1);

    // Simultaneous pulses under backpressure
    cyc();
    trig_ready = 1'b0;
    gate_pulse = 16'h8102;
    exp_q.push_back(gate_id_t'(1));
    exp_q.push_back(gate_id_t'(8));
    exp_q.push_back(gate_id_t'(15));
    cyc();
    gate_pulse = '0;
    for (int c = 2; c < 5; c++) begin
      cyc(); smp();
      chk("bp_stall_valid", int'(trig_valid), 1);
      chk("bp_stall_id", int'(trig_id), 1);
    end
    cyc();
    trig_ready = 1'b1;
    drain("bp", 20);

    // Ordering across cycles
    cyc();
    gate_pulse = 16'h0200;
    exp_q.push_back(gate_id_t'(9));
    cyc();
    gate_pulse = 16'h0004;
    exp_q.push_back(gate_id_t'(2));
    cyc();
    gate_pulse = '0;
    drain("order", 20);

    // Duplicate while in flight, then re-fire in the pop cycle
    cyc();
    trig_ready = 1'b0;
    gate_pulse = 16'h0008;
    exp_q.push_back(gate_id_t'(3));
    cyc();
    gate_pulse = '0;
    smp();
    chk("dup_before", int'(dup_err), 0);
    cyc();
    gate_pulse = 16'h0008;
    cyc();
    gate_pulse = '0;
    smp();
    chk("dup_set", int'(dup_err), 1);
    chk("dup_head", int'(trig_id), 3);
    issued = 0;
    cyc();
    trig_ready = 1'b1;
    gate_pulse = 16'h0008;
    exp_q.push_back(gate_id_t'(3));
    cyc();
    gate_pulse = '0;
    drain("refire", 20);
    chk("refire_count", issued, 2);
    chk("refire_dup_kept", int'(dup_err), 1);

    // Reset clears dup_err; a pulse during reset is dropped
    cyc();
    logic_reset = 1'b1;
    gate_pulse  = 16'h0001;
    cyc();
    logic_reset = 1'b0;
    gate_pulse  = '0;
    smp();
    chk("rst2_dup", int'(dup_err), 0);
    cyc(); cyc(); smp();
    chk("rst2_drop_valid", int'(trig_valid), 0);
    chk("rst2_idle", int'(idle), 1);

    // Full load, partial drain, then reset
    cyc();
    trig_ready = 1'b0;
    gate_pulse = 16'hFFFF;
    for (int i = 0; i < 16; i++) exp_q.push_back(gate_id_t'(i));
    cyc();
    gate_pulse = '0;
    repeat (17) cyc();
    smp();
    chk("full_valid", int'(trig_valid), 1);
    chk("full_head", int'(trig_id), 0);
    chk("full_idle", int'(idle), 0);
    cyc();
    trig_ready = 1'b1;
    repeat (4) cyc();
    logic_reset = 1'b1;
    trig_ready  = 1'b0;
    chk("full_popped", exp_q.size(), 12);
    exp_q.delete();
    cyc();
    logic_reset = 1'b0;
    trig_ready  = 1'b1;
    smp();
    chk("full_rst_valid", int'(trig_valid), 0);
    chk("full_rst_idle", int'(idle), 1);
    repeat (3) cyc();
    smp();
    chk("full_rst_quiet", int'(trig_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_trigger_queue.md
Name: gate_trigger_queue

Overview:
- Downstream consumer of the per-gate fire pulses produced by the logic-gate stage.
- Collects one-cycle fire pulses from N_GATES gate instances and serialises them into an ordered stream of gate IDs.
- Hands each ID to the wire-propagation engine over a valid/ready handshake.
- Reports when the logic frame has fully drained (idle) and flags illegal re-fires of a gate still in flight.

Parameters:
- N_GATES, 16, number of gate pulse inputs (>=2).
- ID_W, $clog2(N_GATES), width of trig_id.
- FIFO_DEPTH, N_GATES, ordering FIFO depth; must be >= N_GATES.

Ports:
- clk  input  1  single clock, all state on posedge.
- logic_reset  input  1  synchronous, active-high reset; also used as the per-frame clear.
- gate_pulse  input  N_GATES  bit i high for one cycle = gate i fired.
- trig_valid  output  1  trig_id holds a pending gate.
- trig_ready  input  1  propagation engine accepts trig_id this cycle.
- trig_id  output  ID_W  index of the gate to propagate.
- idle  output  1  nothing pending, queued or arriving.
- dup_err  output  1  sticky; a pulse arrived for a gate already in flight.

Behaviour:
- Reset:
  - logic_reset high at a posedge clears pending, in_queue, the FIFO and dup_err.
  - Reset outputs: trig_valid=0, trig_id=0, idle=1, dup_err=0.
  - Reset mid-operation discards all queued IDs with no further trig_valid.
  - Pulses coinciding with reset are dropped.
- In-flight tracking:
  - Gate i is in flight while pending[i] or in_queue[i] is set.
  - A pulse on gate i while it is in flight sets dup_err and is otherwise ignored; no state change for i.
  - Exception: if gate i is popped (trig_valid&&trig_ready with trig_id==i) in the same cycle, the pulse is accepted. It sets pending[i].
- Capture, cycle N: each accepted pulse sets pending[i] at the posedge ending cycle N.
- Stage, one per cycle:
  - If pending is non-zero, the lowest set index j is pushed into the FIFO.
  - On that push, pending[j] clears and in_queue[j] sets.
  - Simultaneous pulses therefore enter the FIFO in ascending index order.
  - Pulses from earlier cycles always precede later ones already staged.
- Issue:
  - FIFO head drives trig_id and trig_valid = !fifo_empty.
  - Pop on trig_valid&&trig_ready, which clears in_queue[trig_id].
  - trig_id is held stable while trig_valid&&!trig_ready.
  - trig_id = 0 when empty.
- Latency: with an empty system, a pulse in cycle 0 gives trig_valid=1 in cycle 2 (capture edge, then stage edge).
- Throughput: one ID per cycle when trig_ready stays high.
- FIFO bounds:
  - Full cannot occur, since at most N_GATES IDs are in flight and FIFO_DEPTH >= N_GATES.
  - An assertion must fire on push-while-full.
  - Push and pop in the same cycle are allowed at any occupancy, including empty→1 and full→full.
- idle = (pending==0) && fifo_empty && (gate_pulse==0). It is combinational and drops in the same cycle a pulse arrives.
- dup_err clears only on logic_reset.

Decomposition:
- Shared package wirelog_pkg holds:
  - the N_GATES default;
  - typedef gate_id_t (logic [ID_W-1:0]);
  - a lowest-set-bit function.
- Sub-module gate_trig_fifo: synchronous single-clock FIFO with FIFO_DEPTH and width ID_W.
  - Ports: push, pop, din, dout, empty, full.
  - Pointer wrap-around is done with an extra MSB.

Test Plan:
- Reset: hold logic_reset 2 cycles, then release -> trig_valid=0, idle=1, dup_err=0.
- Single pulse: gate_pulse=16'h0020 in cycle 0, trig_ready=1 -> trig_valid=1, trig_id=5 in cycle 2 only; idle=1 from cycle 3.
- Simultaneous pulses with backpressure:
  - Stimulus: gate_pulse=16'h8102 in one cycle, trig_ready=0 for 5 cycles, then 1.
  - Response: IDs issued 1, 8, 15 in order; trig_id stays 1 while stalled.
- Ordering across cycles: pulse gate 9 in cycle 0, gate 2 in cycle 1, trig_ready=1 -> issue order 9 then 2.
- Duplicate and re-fire:
  - Pulse gate 3 twice while trig_ready=0 -> dup_err=1 and exactly one ID 3 issued.
  - Pulse gate 3 in the cycle it is popped -> accepted, ID 3 issued again, dup_err unchanged.
- Full load plus reset:
  - Pulse all 16 gates with trig_ready=0 -> FIFO holds 0..15, no assertion.
  - Assert logic_reset mid-drain -> trig_valid=0 the next cycle, idle=1.
